control_sequencer: RTL and testbench

CONTROL_SEQUENCER -- requirements
Module: control_sequencer

---
 rtl/control_sequencer.sv | 144 ++++++++++++++
 tb/tb_control_sequencer.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/control_sequencer.sv
// control_sequencer
//   Microcode sequencer for a small 8-bit bus machine. A 3-bit step
//   register walks T0..T4; instructions end after their last active step.
//   All control outputs are combinational decodes of step, opcode and flags.
//
//   Build option: CONDITIONAL_JUMP_EN enables JC (0111) and JZ (1000);
//   when undefined both decode as NOP and cf/zf are ignored.
//
//   Ports:
//     clk, rst          rising-edge clock, synchronous active-high reset
//     opcode[3:0]       instruction-register upper nibble (valid from T2)
//     cf, zf            carry / zero flags
//     co_n j_n mi_n ro_n ri_n                active-low PC/memory controls
//     ii_n io_n ai_n ao_n bi_n eo_n oi_n     active-low register controls
//     ce su fi hlt                           active-high controls
//     t_state[2:0]      current microstep
module control_sequencer (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] opcode,
    input  logic       cf,
    input  logic       zf,
    output logic       co_n,
    output logic       j_n,
    output logic       mi_n,
    output logic       ro_n,
    output logic       ri_n,
    output logic       ii_n,
    output logic       io_n,
    output logic       ai_n,
    output logic       ao_n,
    output logic       bi_n,
    output logic       eo_n,
    output logic       oi_n,
    output logic       ce,
    output logic       su,
    output logic       fi,
    output logic       hlt,
    output logic [2:0] t_state
);

    typedef enum logic [2:0] {
        T0 = 3'd0,
        T1 = 3'd1,
        T2 = 3'd2,
        T3 = 3'd3,
        T4 = 3'd4
    } step_e;

    typedef enum logic [3:0] {
        OP_LDA = 4'b0001,
        OP_ADD = 4'b0010,
        OP_SUB = 4'b0011,
        OP_STA = 4'b0100,
        OP_LDI = 4'b0101,
        OP_JMP = 4'b0110,
        OP_JC  = 4'b0111,
        OP_JZ  = 4'b1000,
        OP_OUT = 4'b1110,
        OP_HLT = 4'b1111
    } op_e;

    step_e step;
    logic  halted;
    op_e   op;

    assign op      = op_e'(opcode);
    assign t_state = step;

`ifndef CONDITIONAL_JUMP_EN
    logic unused_flags;
    assign unused_flags = cf ^ zf;
`endif

    // Halting freezes the step at T2 rather than moving on.
    always_ff @(posedge clk) begin
        if (rst) begin
            step   <= T0;
            halted <= 1'b0;
        end else if (!halted) begin
            case (step)
                T0: step <= T1;
                T1: step <= T2;
                T2: begin
                    if (op == OP_HLT)
                        halted <= 1'b1;
                    else if (op == OP_LDA || op == OP_ADD || op == OP_SUB || op == OP_STA)
                        step <= T3;
                    else
                        step <= T0;
                end
                T3: step <= (op == OP_ADD || op == OP_SUB) ? T4 : T0;
                default: step <= T0;
            endcase
        end
    end

    always_comb begin
        co_n = 1'b1; j_n  = 1'b1; mi_n = 1'b1; ro_n = 1'b1; ri_n = 1'b1;
        ii_n = 1'b1; io_n = 1'b1; ai_n = 1'b1; ao_n = 1'b1; bi_n = 1'b1;
        eo_n = 1'b1; oi_n = 1'b1;
        ce   = 1'b0; su   = 1'b0; fi   = 1'b0; hlt  = 1'b0;
        if (rst) begin
            // everything stays inactive
        end else if (halted) begin
            hlt = 1'b1;
        end else begin
            case (step)
                T0: begin co_n = 1'b0; mi_n = 1'b0; end
                T1: begin ro_n = 1'b0; ii_n = 1'b0; ce = 1'b1; end
                T2: begin
                    case (op)
                        OP_LDA, OP_ADD, OP_SUB, OP_STA: begin io_n = 1'b0; mi_n = 1'b0; end
                        OP_LDI: begin io_n = 1'b0; ai_n = 1'b0; end
                        OP_JMP: begin io_n = 1'b0; j_n = 1'b0; end
`ifdef CONDITIONAL_JUMP_EN
                        OP_JC:  begin io_n = 1'b0; j_n = ~cf; end
                        OP_JZ:  begin io_n = 1'b0; j_n = ~zf; end
`endif
                        OP_OUT: begin ao_n = 1'b0; oi_n = 1'b0; end
                        OP_HLT: hlt = 1'b1;
                        default: ;
                    endcase
                end
                T3: begin
                    case (op)
                        OP_LDA: begin ro_n = 1'b0; ai_n = 1'b0; end
                        OP_ADD, OP_SUB: begin ro_n = 1'b0; bi_n = 1'b0; end
                        OP_STA: begin ao_n = 1'b0; ri_n = 1'b0; end
                        default: ;
                    endcase
                end
                T4: begin
                    if (op == OP_ADD || op == OP_SUB) begin
                        eo_n = 1'b0; ai_n = 1'b0; fi = 1'b1;
                        su   = (op == OP_SUB);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_control_sequencer.sv
// tb_control_sequencer
//   Directed-vector bench for control_sequencer. Controls are packed into
//   one 16-bit word; expected words are the all-inactive pattern with the
//   listed active controls flipped.
module tb_control_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] opcode;
    logic       cf, zf;
    logic       co_n, j_n, mi_n, ro_n, ri_n, ii_n, io_n, ai_n, ao_n, bi_n, eo_n, oi_n;
    logic       ce, su, fi, hlt;
    logic [2:0] t_state;

    int unsigned checks = 0;
    int unsigned errors = 0;

    localparam logic [15:0] INACT = 16'hFFF0;
    localparam logic [15:0] CO  = 16'h8000, J   = 16'h4000, MI = 16'h2000, RO = 16'h1000;
    localparam logic [15:0] RI  = 16'h0800, II  = 16'h0400, IO = 16'h0200, AI = 16'h0100;
    localparam logic [15:0] AO  = 16'h0080, BI  = 16'h0040, EO = 16'h0020, OI = 16'h0010;
    localparam logic [15:0] CE  = 16'h0008, SU  = 16'h0004, FI = 16'h0002, HLT = 16'h0001;

    logic [15:0] ctl;
    assign ctl = {co_n, j_n, mi_n, ro_n, ri_n, ii_n, io_n, ai_n,
                  ao_n, bi_n, eo_n, oi_n, ce, su, fi, hlt};

    control_sequencer dut (
        .clk(clk), .rst(rst), .opcode(opcode), .cf(cf), .zf(zf),
        .co_n(co_n), .j_n(j_n), .mi_n(mi_n), .ro_n(ro_n), .ri_n(ri_n),
        .ii_n(ii_n), .io_n(io_n), .ai_n(ai_n), .ao_n(ao_n), .bi_n(bi_n),
        .eo_n(eo_n), .oi_n(oi_n), .ce(ce), .su(su), .fi(fi), .hlt(hlt),
        .t_state(t_state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Check the current cycle without waiting.
    task automatic expect_now(input string tag, input logic [2:0] t, input logic [15:0] active);
        check({tag, "_t"}, {29'd0, t_state}, {29'd0, t});
        check({tag, "_ctl"}, {16'd0, ctl}, {16'd0, INACT ^ active});
    endtask

    // Advance to the middle of the next cycle, then check.
    task automatic expect_cycle(input string tag, input logic [2:0] t, input logic [15:0] active);
        @(negedge clk);
        expect_now(tag, t, active);
    endtask

    task automatic fetch(input string tag);
        expect_cycle({tag, "_T1"}, 3'd1, RO | II | CE);
    endtask

    logic [15:0] jc_taken;

    initial begin
        rst = 1'b1; opcode = 4'b0000; cf = 1'b0; zf = 1'b0;

        // Reset held: controls inactive, step at T0
        @(negedge clk);
        @(negedge clk);
        expect_now("rst_hold", 3'd0, 16'h0000);
        rst = 1'b0; opcode = 4'b0001;
        #1 expect_now("rel_T0", 3'd0, CO | MI);

        // LDA
        fetch("lda");
        expect_cycle("lda_T2", 3'd2, IO | MI);
        expect_cycle("lda_T3", 3'd3, RO | AI);
        expect_cycle("lda_T0", 3'd0, CO | MI);

        // SUB
        opcode = 4'b0011;
        fetch("sub");
        expect_cycle("sub_T2", 3'd2, IO | MI);
        expect_cycle("sub_T3", 3'd3, RO | BI);
        expect_cycle("sub_T4", 3'd4, EO | AI | FI | SU);
        expect_cycle("sub_T0", 3'd0, CO | MI);

        // JC taken / not taken
`ifdef CONDITIONAL_JUMP_EN
        jc_taken = IO | J;
`else
        jc_taken = 16'h0000;
`endif
        opcode = 4'b0111; cf = 1'b1;
        fetch("jc1");
        expect_cycle("jc1_T2", 3'd2, jc_taken);
        cf = 1'b0;
        expect_cycle("jc1_T0", 3'd0, CO | MI);
        fetch("jc0");
`ifdef CONDITIONAL_JUMP_EN
        expect_cycle("jc0_T2", 3'd2, IO);
`else
        expect_cycle("jc0_T2", 3'd2, 16'h0000);
`endif
        expect_cycle("jc0_T0", 3'd0, CO | MI);

        // JZ taken, with cf high to show it is ignored
        opcode = 4'b1000; zf = 1'b1; cf = 1'b1;
        fetch("jz1");
        expect_cycle("jz1_T2", 3'd2, jc_taken);
        zf = 1'b0; cf = 1'b0;
        expect_cycle("jz1_T0", 3'd0, CO | MI);

        // STA
        opcode = 4'b0100;
        fetch("sta");
        expect_cycle("sta_T2", 3'd2, IO | MI);
        expect_cycle("sta_T3", 3'd3, AO | RI);
        expect_cycle("sta_T0", 3'd0, CO | MI);

        // LDI, JMP, OUT: single execute step
        opcode = 4'b0101;
        fetch("ldi");
        expect_cycle("ldi_T2", 3'd2, IO | AI);
        expect_cycle("ldi_T0", 3'd0, CO | MI);
        opcode = 4'b0110;
        fetch("jmp");
        expect_cycle("jmp_T2", 3'd2, IO | J);
        expect_cycle("jmp_T0", 3'd0, CO | MI);
        opcode = 4'b1110;
        fetch("out");
        expect_cycle("out_T2", 3'd2, AO | OI);
        expect_cycle("out_T0", 3'd0, CO | MI);

        // NOP opcode 1010
        opcode = 4'b1010;
        fetch("nop");
        expect_cycle("nop_T2", 3'd2, 16'h0000);
        expect_cycle("nop_T0", 3'd0, CO | MI);

        // ADD interrupted by reset at T3
        opcode = 4'b0010;
        fetch("addr");
        expect_cycle("addr_T2", 3'd2, IO | MI);
        expect_cycle("addr_T3", 3'd3, RO | BI);
        rst = 1'b1;
        #1 expect_now("addr_rstT3", 3'd3, 16'h0000);
        expect_cycle("addr_rst", 3'd0, 16'h0000);
        rst = 1'b0;
        #1 expect_now("addr_relT0", 3'd0, CO | MI);

        // HLT: freeze at T2 for 10 cycles, then reset recovers
        opcode = 4'b1111;
        fetch("hlt");
        expect_cycle("hlt_T2", 3'd2, HLT);
        for (int i = 0; i < 10; i++)
            expect_cycle("hlt_hold", 3'd2, HLT);
        rst = 1'b1;
        #1 expect_now("hlt_rst", 3'd2, 16'h0000);
        expect_cycle("hlt_rst2", 3'd0, 16'h0000);
        rst = 1'b0; opcode = 4'b0000;
        #1 expect_now("hlt_relT0", 3'd0, CO | MI);
        fetch("post");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
